// File: rtl/sequence_emitter.sv
// Transmit side of the 3-bit symbol link: emits the 7-symbol frame repeat_cnt+1 times
// with gap idle cycles between frames. Optional SEQ_ALT_TAIL_EN adds tail_sel (last symbol 101).
module sequence_emitter #(
  parameter int REPEAT_W = 4,
  parameter int GAP_W    = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [REPEAT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0]    gap,
`ifdef SEQ_ALT_TAIL_EN
  input  logic                tail_sel,
`endif
  input  logic                data_ready,
  output logic [2:0]          data,
  output logic                data_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  function automatic logic [2:0] sym_rom(input logic [2:0] idx, input logic alt);
    case (idx)
      3'd0:    sym_rom = 3'b001;
      3'd1:    sym_rom = 3'b101;
      3'd2:    sym_rom = 3'b110;
      3'd3:    sym_rom = 3'b000;
      3'd4:    sym_rom = 3'b110;
      3'd5:    sym_rom = 3'b110;
      3'd6:    sym_rom = alt ? 3'b101 : 3'b011;
      default: sym_rom = 3'b111;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          sym_idx_q, sym_idx_d;
  logic [REPEAT_W-1:0] frame_ctr_q, frame_ctr_d, repeat_q, repeat_d;
  logic [GAP_W-1:0]    gap_ctr_q, gap_ctr_d, gap_q, gap_d;
  logic [2:0]          data_q, data_d;
  logic                data_valid_q, data_valid_d, busy_q, busy_d, done_q, done_d;
  logic                tail_q, tail_d;
  logic                xfer;

  always_comb begin
    state_d     = state_q;
    sym_idx_d   = sym_idx_q;
    frame_ctr_d = frame_ctr_q;
    gap_ctr_d   = gap_ctr_q;
    repeat_d    = repeat_q;
    gap_d       = gap_q;
    tail_d      = tail_q;
    done_d      = 1'b0;
    xfer        = data_valid_q & data_ready;
    case (state_q)
      IDLE: if (start) begin
        state_d     = SEND;
        sym_idx_d   = 3'd0;
        frame_ctr_d = '0;
        repeat_d    = repeat_cnt;
        gap_d       = gap;
`ifdef SEQ_ALT_TAIL_EN
        tail_d      = tail_sel;
`endif
      end
      SEND: if (xfer) begin
        if (sym_idx_q == 3'd6) begin
          sym_idx_d = 3'd0;
          // Compare before incrementing so all-ones repeat_cnt never wraps.
          if (frame_ctr_q == repeat_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            frame_ctr_d = frame_ctr_q + 1'b1;
            if (gap_q != '0) begin
              state_d   = GAP;
              gap_ctr_d = gap_q;
            end
          end
        end else begin
          sym_idx_d = sym_idx_q + 3'd1;
        end
      end
      GAP: begin
        gap_ctr_d = gap_ctr_q - 1'b1;
        if (gap_ctr_q == GAP_W'(1)) state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      sym_idx_d = 3'd0;
      done_d    = 1'b0;
    end
    // Outputs are computed from next state so they register alongside it.
    data_valid_d = (state_d == SEND);
    data_d       = data_valid_d ? sym_rom(sym_idx_d, tail_d) : 3'b111;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sym_idx_q    <= 3'd0;
      frame_ctr_q  <= '0;
      gap_ctr_q    <= '0;
      repeat_q     <= '0;
      gap_q        <= '0;
      tail_q       <= 1'b0;
      data_q       <= 3'b111;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sym_idx_q    <= sym_idx_d;
      frame_ctr_q  <= frame_ctr_d;
      gap_ctr_q    <= gap_ctr_d;
      repeat_q     <= repeat_d;
      gap_q        <= gap_d;
      tail_q       <= tail_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sequence_emitter.sv
// Directed bench for sequence_emitter; a small frame-matching model stands in for the detector.
module tb_sequence_emitter;
  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0, data_ready = 1'b1;
  logic [3:0] repeat_cnt = '0, gap = '0;
  logic [2:0] data;
  logic       data_valid, busy, done;
`ifdef SEQ_ALT_TAIL_EN
  logic       tail_sel = 1'b1;
`endif

  int n_chk = 0, n_fail = 0;
  logic [2:0] frm [7];
  logic [2:0] win [7];
  logic [2:0] last_sym;

  sequence_emitter #(.REPEAT_W(4), .GAP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .repeat_cnt(repeat_cnt), .gap(gap),
`ifdef SEQ_ALT_TAIL_EN
    .tail_sel(tail_sel),
`endif
    .data_ready(data_ready), .data(data), .data_valid(data_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] rc, input logic [3:0] g);
    repeat_cnt = rc;
    gap        = g;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Counts beats, done pulses, complete frames seen on transfers and idle cycles while busy.
  task automatic run_count(input int cycles, input bit poke,
                           output int beats, output int dones, output int found, output int idles);
    beats = 0; dones = 0; found = 0; idles = 0;
    for (int k = 0; k < 7; k++) win[k] = 3'b111;
    for (int i = 0; i < cycles; i++) begin
      start = poke && (i < 13) && (i % 3 == 1);
      if (done) dones++;
      if (busy && !data_valid) idles++;
      if (data_valid && data_ready) begin
        bit m;
        beats++;
        last_sym = data;
        for (int k = 0; k < 6; k++) win[k] = win[k+1];
        win[6] = data;
        m = 1'b1;
        for (int k = 0; k < 7; k++) if (win[k] !== frm[k]) m = 1'b0;
        if (m) found++;
      end
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    int b, d, f, id;
    logic [2:0] t3 [11];
    frm = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011};
`ifdef SEQ_ALT_TAIL_EN
    frm[6] = 3'b101;
`endif
    t3 = '{3'b001, 3'b101, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
           3'b000, 3'b110, 3'b110, frm[6]};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data, 3'b111);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    tick();

    // 1: single frame, back-to-back symbols
    kick(4'd0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t1_sym%0d", i), {busy, data_valid, data}, {2'b11, frm[i]});
      chk("t1_nodone", done, 0);
      tick();
    end
    chk("t1_done", {done, busy, data_valid, data}, {3'b100, 3'b111});
    tick();
    chk("t1_done_pulse", done, 0);

    // 2: three frames with 3-cycle gaps
    kick(4'd2, 4'd3);
    for (int c = 0; c < 27; c++) begin
      int p;
      p = c % 10;
      if (p < 7) chk($sformatf("t2_c%0d", c), {data_valid, data, done}, {1'b1, frm[p], 1'b0});
      else       chk($sformatf("t2_c%0d", c), {busy, data_valid, data, done}, {2'b10, 3'b111, 1'b0});
      tick();
    end
    chk("t2_done", {done, busy}, 2'b10);
    tick();
    chk("t2_done_once", done, 0);

    // 3: stall for 4 cycles on symbol 110
    kick(4'd0, 4'd0);
    for (int c = 0; c < 11; c++) begin
      data_ready = !(c >= 2 && c <= 5);
      chk($sformatf("t3_c%0d", c), {data_valid, data}, {1'b1, t3[c]});
      tick();
    end
    data_ready = 1'b1;
    chk("t3_done", done, 1);
    tick();

    // 4: abort during the gap after frame 2
    kick(4'd2, 4'd3);
    repeat (18) tick();
    chk("t4_in_gap", {busy, data_valid}, 2'b10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort", {busy, data_valid, data, done}, {2'b00, 3'b111, 1'b0});
    run_count(30, 1'b0, b, d, f, id);
    chk("t4_no_done", d, 0);
    chk("t4_no_beats", b, 0);
    abort = 1'b1;
    kick(4'd2, 4'd3);
    abort = 1'b0;
    chk("t4_abort_start", busy, 0);
    kick(4'd2, 4'd3);
    chk("t4_restart", {data_valid, data}, {1'b1, 3'b001});
    run_count(30, 1'b0, b, d, f, id);
    chk("t4_restart_beats", b, 21);
    chk("t4_restart_done", d, 1);

    // 5: async reset mid-frame, then start pulses while busy
    kick(4'd1, 4'd0);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_rst", {busy, data_valid, data}, {2'b00, 3'b111});
    #1 reset_n = 1'b1;
    tick();
    chk("t5_idle", busy, 0);
    kick(4'd1, 4'd0);
    run_count(20, 1'b1, b, d, f, id);
    chk("t5_beats", b, 14);
    chk("t5_done", d, 1);
    chk("t5_frames", f, 2);

    // Max repeat count: 16 frames, no wrap
    kick(4'd15, 4'd0);
    run_count(120, 1'b0, b, d, f, id);
    chk("max_beats", b, 112);
    chk("max_frames", f, 16);
    chk("max_done", d, 1);

    // 6: detector-style frame count, repeat_cnt=1, gap=2
    kick(4'd1, 4'd2);
    run_count(25, 1'b0, b, d, f, id);
    chk("t6_frames", f, 2);
    chk("t6_gap_idles", id, 2);
    chk("t6_done", d, 1);
    chk("t6_tail", last_sym, frm[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
